// File: rtl/maxpool_flatten.sv
// maxpool_flatten: streaming 2x2 binary max-pool (OR) that flattens a raster feature map into data_out.
// Define MAXPOOL_FLATTEN_ERR_EN to add a sticky err output that flags pixels offered while holding.
module maxpool_flatten #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int NUM_OUTPUTS = (IMG_W/2)*(IMG_H/2)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   pixel_in,
  input  logic                   pixel_valid,
  output logic                   pixel_ready,
  output logic [NUM_OUTPUTS-1:0] data_out,
  output logic                   out_valid,
  input  logic                   out_ack
`ifdef MAXPOOL_FLATTEN_ERR_EN
  ,
  output logic                   err
`endif
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int OW = $clog2(NUM_OUTPUTS);
  typedef enum logic {COLLECT, HOLD} state_t;
  state_t state, state_next;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [IMG_W/2-1:0] line_buf;
  logic held;
  logic accept, last_col, last_row, flush;
  logic [CW-2:0] lb_idx;
  logic [OW-1:0] out_idx;
  assign accept   = pixel_valid && pixel_ready;
  assign last_col = col == CW'(IMG_W-1);
  assign last_row = row == RW'(IMG_H-1);
  assign flush    = clear || (state == HOLD && out_ack);
  assign lb_idx   = col[CW-1:1];
  assign out_idx  = OW'(row >> 1) * OW'(IMG_W/2) + OW'(col >> 1);
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= COLLECT;
    else state <= state_next;
  always_comb
    state_next = clear ? COLLECT :
                 state == COLLECT ? ((accept && last_col && last_row) ? HOLD : COLLECT) :
                 (out_ack ? COLLECT : HOLD);
  always_comb begin
    pixel_ready = state == COLLECT;
    out_valid   = state == HOLD;
  end
  // even rows fold column pairs into line_buf; odd rows finish the 2x2 window into data_out
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      col      <= '0;
      row      <= '0;
      line_buf <= '0;
      held     <= 1'b0;
      data_out <= '0;
    end else if (flush) begin
      col      <= '0;
      row      <= '0;
      line_buf <= '0;
      held     <= 1'b0;
      data_out <= '0;
    end else if (accept) begin
      col <= last_col ? '0 : col + 1'b1;
      row <= !last_col ? row : last_row ? '0 : row + 1'b1;
      if (!row[0]) line_buf[lb_idx] <= col[0] ? (line_buf[lb_idx] | pixel_in) : pixel_in;
      else if (!col[0]) held <= pixel_in;
      else data_out[out_idx] <= line_buf[lb_idx] | held | pixel_in;
    end
`ifdef MAXPOOL_FLATTEN_ERR_EN
  always_ff @(posedge clock or negedge reset)
    if (!reset) err <= 1'b0;
    else if (clear) err <= 1'b0;
    else if (state == HOLD && pixel_valid) err <= 1'b1;
`endif
endmodule

// File: tb/tb_maxpool_flatten.sv
// tb_maxpool_flatten: table-driven, hand-written and randomized frames checked against an array-based pooling model.
module tb_maxpool_flatten;
  localparam int W = 28;
  localparam int H = 28;
  localparam int N = (W/2)*(H/2);
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;
  logic pixel_in = 1'b0;
  logic pixel_valid = 1'b0;
  logic out_ack = 1'b0;
  logic pixel_ready, out_valid;
  logic [N-1:0] data_out;
`ifdef MAXPOOL_FLATTEN_ERR_EN
  logic err;
`endif
  int n_chk = 0;
  int n_fail = 0;
  bit img [W*H];
  typedef struct {int r; int c; int bit_idx;} vec_t;
  vec_t tbl [6];

  maxpool_flatten #(.IMG_W(W), .IMG_H(H), .NUM_OUTPUTS(N)) dut (
    .clock(clock), .reset(reset), .clear(clear), .pixel_in(pixel_in),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .data_out(data_out),
    .out_valid(out_valid), .out_ack(out_ack)
`ifdef MAXPOOL_FLATTEN_ERR_EN
    , .err(err)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [N-1:0] pool_model();
    logic [N-1:0] m = '0;
    for (int r = 0; r < H/2; r++)
      for (int c = 0; c < W/2; c++)
        m[r*(W/2)+c] = img[(2*r)*W+2*c] | img[(2*r)*W+2*c+1] | img[(2*r+1)*W+2*c] | img[(2*r+1)*W+2*c+1];
    return m;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic fill_random(input int pct);
    for (int p = 0; p < W*H; p++) img[p] = $urandom_range(99) < pct;
  endtask

  task automatic fill_zero();
    for (int p = 0; p < W*H; p++) img[p] = 1'b0;
  endtask

  task automatic send_pixels(input int count, input int gap_pct);
    int t;
    for (int p = 0; p < count; p++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        pixel_valid = 1'b0;
        pixel_in = 1'($urandom_range(1));
        step();
      end
      pixel_in = img[p];
      pixel_valid = 1'b1;
      t = 0;
      while (!pixel_ready && t < 8) begin
        step();
        t++;
      end
      if (!pixel_ready) begin
        n_chk++;
        n_fail++;
        $display("FAIL accept_timeout: pixel %0d never accepted", p);
        pixel_valid = 1'b0;
        return;
      end
      if (p == W*H-1) chk1("valid_before_last_accept", out_valid, 1'b0);
      step();
    end
    pixel_valid = 1'b0;
  endtask

  task automatic frame_check(input string name, input int gap_pct);
    send_pixels(W*H, gap_pct);
    chk1({name, "_out_valid"}, out_valid, 1'b1);
    chk1({name, "_ready_low"}, pixel_ready, 1'b0);
    chk({name, "_data"}, data_out, pool_model());
  endtask

  task automatic ack();
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
    chk1("ack_out_valid", out_valid, 1'b0);
    chk("ack_data_zero", data_out, '0);
  endtask

  initial begin
    logic [N-1:0] snap;
    tbl[0] = '{0, 0, 0};
    tbl[1] = '{1, 1, 0};
    tbl[2] = '{3, 5, 16};
    tbl[3] = '{0, 27, 13};
    tbl[4] = '{26, 0, 182};
    tbl[5] = '{10, 11, 75};
    step();
    step();
    chk1("reset_out_valid", out_valid, 1'b0);
    chk1("reset_ready", pixel_ready, 1'b1);
    chk("reset_data", data_out, '0);
    reset = 1'b1;
    step();
    fill_random(50);
    send_pixels(300, 0);
    reset = 1'b0;
    #2;
    chk1("midreset_out_valid", out_valid, 1'b0);
    chk1("midreset_ready", pixel_ready, 1'b1);
    chk("midreset_data", data_out, '0);
    step();
    reset = 1'b1;
    step();
    fill_random(30);
    frame_check("after_reset", 0);
    ack();
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
    chk1("ack_in_collect_ignored", pixel_ready, 1'b1);
    fill_zero();
    frame_check("all_zero", 0);
    chk("all_zero_const", data_out, '0);
    ack();
    foreach (tbl[i]) begin
      fill_zero();
      img[tbl[i].r*W+tbl[i].c] = 1'b1;
      send_pixels(W*H, 0);
      chk1($sformatf("tbl%0d_valid", i), out_valid, 1'b1);
      chk($sformatf("tbl%0d_data", i), data_out, N'(1) << tbl[i].bit_idx);
      ack();
    end
    fill_zero();
    img[27*W+27] = 1'b1;
    frame_check("corner", 40);
    chk("corner_bit195", data_out, N'(1) << 195);
    snap = data_out;
    pixel_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pixel_in = 1'($urandom_range(1));
      step();
    end
    pixel_valid = 1'b0;
    chk("hold_data_stable", data_out, snap);
    chk1("hold_still_valid", out_valid, 1'b1);
`ifdef MAXPOOL_FLATTEN_ERR_EN
    chk1("err_set", err, 1'b1);
`endif
    ack();
    for (int p = 0; p < W*H; p++) img[p] = 1'(((p / W) + (p % W)) & 1);
    frame_check("checker", 0);
    chk("checker_all_ones", data_out, '1);
    ack();
    fill_random(50);
    send_pixels(200, 10);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_mid_data", data_out, '0);
    for (int f = 0; f < 4; f++) begin
      fill_random(2 + 6*f);
      frame_check($sformatf("rand%0d", f), 20);
      ack();
    end
    fill_random(10);
    frame_check("pre_clear", 0);
    pixel_valid = 1'b1;
    step();
    pixel_valid = 1'b0;
    clear = 1'b1;
    out_ack = 1'b1;
    step();
    clear = 1'b0;
    out_ack = 1'b0;
    chk1("clear_ack_out_valid", out_valid, 1'b0);
    chk1("clear_ack_ready", pixel_ready, 1'b1);
    chk("clear_ack_data", data_out, '0);
`ifdef MAXPOOL_FLATTEN_ERR_EN
    chk1("clear_ack_err", err, 1'b0);
`endif
    fill_random(5);
    frame_check("post_clear", 0);
    ack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
